// File: rtl/circ_fifo_pkg.sv
// Shared helpers and types for the circ_fifo_mon block.
package circ_fifo_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_FIFO_DEPTH = 10;
    localparam int unsigned LVL_W          = clog2_min1(DEF_FIFO_DEPTH + 1);
    localparam int unsigned PTR_W          = clog2_min1(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/circ_fifo_mon_stats.sv
// High watermark and saturating overflow/underflow counters for circ_fifo_mon.
module circ_fifo_mon_stats
    import circ_fifo_pkg::*;
#(
    parameter int unsigned LEVEL_W   = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [LEVEL_W-1:0]   level_next_i,
    input  logic                 ovf_inc_i,
    input  logic                 udf_inc_i,
    output logic [LEVEL_W-1:0]   max_level_o,
    output logic [CNT_WIDTH-1:0] ovf_cnt_o,
    output logic [CNT_WIDTH-1:0] udf_cnt_o
);

    logic [LEVEL_W-1:0]   max_level_q, max_level_d;
    logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_WIDTH-1:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        max_level_d = max_level_q;
        ovf_cnt_d   = ovf_cnt_q;
        udf_cnt_d   = udf_cnt_q;
        // Clear wins over a same-cycle increment; watermark restarts at the new level.
        if (clr_i) begin
            max_level_d = level_next_i;
            ovf_cnt_d   = '0;
            udf_cnt_d   = '0;
        end else begin
            if (level_next_i > max_level_q) begin
                max_level_d = level_next_i;
            end
            if (ovf_inc_i && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
            if (udf_inc_i && (udf_cnt_q != '1)) begin
                udf_cnt_d = udf_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_level_q <= '0;
            ovf_cnt_q   <= '0;
            udf_cnt_q   <= '0;
        end else begin
            max_level_q <= max_level_d;
            ovf_cnt_q   <= ovf_cnt_d;
            udf_cnt_q   <= udf_cnt_d;
        end
    end

    assign max_level_o = max_level_q;
    assign ovf_cnt_o   = ovf_cnt_q;
    assign udf_cnt_o   = udf_cnt_q;

endmodule

// File: rtl/circ_fifo_mon.sv
// Single-clock circular FIFO with registered flags and occupancy statistics.
// Statistics are built only when CIRC_FIFO_MON_STATS_EN is defined.
module circ_fifo_mon
    import circ_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 10,
    parameter int unsigned AFULL_THR  = 8,
    parameter int unsigned AEMPTY_THR = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    we_i,
    input  logic [DATA_WIDTH-1:0]                   data_i,
    input  logic                                    re_i,
    output logic [DATA_WIDTH-1:0]                   data_o,
    output logic                                    data_vld_o,
    output logic                                    fifo_full_o,
    output logic                                    fifo_empty_o,
    output logic                                    fifo_afull_o,
    output logic                                    fifo_aempty_o,
    output logic [clog2_min1(FIFO_DEPTH+1)-1:0]     level_o,
    output logic [clog2_min1(FIFO_DEPTH+1)-1:0]     max_level_o,
    output logic [CNT_WIDTH-1:0]                    ovf_cnt_o,
    output logic [CNT_WIDTH-1:0]                    udf_cnt_o,
    input  logic                                    clr_stats_i
);

    localparam int unsigned LW = clog2_min1(FIFO_DEPTH + 1);
    localparam int unsigned PW = clog2_min1(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    occ_e                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        rd_acc   = re_i & (occ_q != OCC_EMPTY);
        wr_acc   = we_i & ((occ_q != OCC_FULL) | rd_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        vld_d    = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            data_d   = mem_q[rd_ptr_q];
        end

        level_d = level_q + LW'(wr_acc) - LW'(rd_acc);

        // Occupancy state follows the next level so flags line up with level_o.
        if (level_d == '0) begin
            occ_d = OCC_EMPTY;
        end else if (level_d == LW'(FIFO_DEPTH)) begin
            occ_d = OCC_FULL;
        end else begin
            occ_d = OCC_PARTIAL;
        end

        afull_d  = (level_d >= LW'(AFULL_THR));
        aempty_d = (level_d <= LW'(AEMPTY_THR));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            occ_q    <= OCC_EMPTY;
            data_q   <= '0;
            vld_q    <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            occ_q    <= occ_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o        = data_q;
    assign data_vld_o    = vld_q;
    assign fifo_full_o   = (occ_q == OCC_FULL);
    assign fifo_empty_o  = (occ_q == OCC_EMPTY);
    assign fifo_afull_o  = afull_q;
    assign fifo_aempty_o = aempty_q;
    assign level_o       = level_q;

`ifdef CIRC_FIFO_MON_STATS_EN
    circ_fifo_mon_stats #(
        .LEVEL_W   (LW),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr_stats_i),
        .level_next_i (level_d),
        .ovf_inc_i    (we_i & ~wr_acc),
        .udf_inc_i    (re_i & ~rd_acc),
        .max_level_o  (max_level_o),
        .ovf_cnt_o    (ovf_cnt_o),
        .udf_cnt_o    (udf_cnt_o)
    );
`else
    logic stats_unused;
    assign stats_unused = clr_stats_i;
    assign max_level_o  = '0;
    assign ovf_cnt_o    = '0;
    assign udf_cnt_o    = '0;
`endif

endmodule

// File: doc/circ_fifo_mon.md
Name: circ_fifo_mon

Overview:
Parametrised single-clock circular FIFO with built-in occupancy monitoring for buffer-size estimation. It is the successor of the basic sync circ_fifo and is generalised in data width, non-power-of-two depth and programmable almost-full/almost-empty thresholds. It adds a high-watermark register and saturating overflow/underflow counters. Throughput benches instantiate it whenever write and read rates share one clock, and read the statistics at the end of a run to size the buffer.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
FIFO_DEPTH, 10, number of entries (>=2, need not be a power of two)
AFULL_THR, 8, fifo_afull_o asserts when level >= AFULL_THR (1..FIFO_DEPTH)
AEMPTY_THR, 2, fifo_aempty_o asserts when level <= AEMPTY_THR (0..FIFO_DEPTH-1)
CNT_WIDTH, 16, width of the overflow and underflow counters

Ports:
clk_i  in  1  single clock
rst_i  in  1  asynchronous reset, active-high
we_i  in  1  write request
data_i  in  DATA_WIDTH  write data
re_i  in  1  read request
data_o  out  DATA_WIDTH  read data, registered
data_vld_o  out  1  data_o valid pulse
fifo_full_o  out  1  level == FIFO_DEPTH
fifo_empty_o  out  1  level == 0
fifo_afull_o  out  1  almost full
fifo_aempty_o  out  1  almost empty
level_o  out  LVL_W  current occupancy, LVL_W = $clog2(FIFO_DEPTH+1)
max_level_o  out  LVL_W  high watermark since reset or last clear
ovf_cnt_o  out  CNT_WIDTH  count of rejected writes
udf_cnt_o  out  CNT_WIDTH  count of rejected reads
clr_stats_i  in  1  synchronous clear of the watermark and both counters

Behaviour:
- Reset (async, rst_i=1): pointers=0, level=0, data_o=0, data_vld_o=0, fifo_empty_o=1, fifo_full_o=0, fifo_aempty_o=1, fifo_afull_o=0, max_level_o=0, ovf_cnt_o=0, udf_cnt_o=0. Reset asserted mid-transfer discards all stored data. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr each have width $clog2(FIFO_DEPTH). Each increments on an accepted access and wraps from FIFO_DEPTH-1 to 0. Full/empty are derived from the level counter, not from pointer comparison.
- Write accept: wr_acc = we_i & (~full | rd_acc).
- Read accept: rd_acc = re_i & ~empty. There is no write-to-read bypass: when the FIFO is empty, a simultaneous write is accepted and the read is rejected.
- Level: level_next = level + wr_acc - rd_acc. When full, a simultaneous read and write are both accepted and the level is unchanged.
- Read latency is 1 cycle. On rd_acc, data_o <= mem[rd_ptr] and data_vld_o=1 on the next cycle. Otherwise data_vld_o=0 and data_o holds its last value.
- All flags are registered outputs that reflect level_next, so they are valid in the cycle after the access.
- Occupancy state, decoded from level: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). Only the transitions EMPTY<->PARTIAL and PARTIAL<->FULL are legal, via single-step level changes.
- Overflow counter: +1 when we_i & ~wr_acc. Underflow counter: +1 when re_i & ~rd_acc. Both saturate at 2^CNT_WIDTH-1.
- Watermark: max_level <= max(max_level, level_next).
- clr_stats_i: next cycle, max_level = level_next and both counters = 0. clr_stats_i takes priority over an increment in the same cycle.

Optional Feature:
CIRC_FIFO_MON_STATS_EN
- Defined: max_level_o, ovf_cnt_o, udf_cnt_o and the clr_stats_i logic are implemented as described above.
- Undefined: these outputs are tied to 0, clr_stats_i is ignored, and no statistics registers are synthesised.
- The FIFO datapath and all flags are identical in both builds.

Decomposition:
- Package circ_fifo_pkg: function clog2_min1 (returns at least 1) and the localparams LVL_W and PTR_W.
- Sub-module circ_fifo_mon_stats: watermark plus the two saturating counters, instantiated only under the macro.
- Storage is an inferred register array inside the top module.

Test Plan:
- Fill to full (DATA_WIDTH=8, DEPTH=10): write 0x00..0x09 on consecutive cycles -> full=1 after the 10th write, afull=1 after the 8th, level_o=10, max_level_o=10. Read all 10 -> data_o 0x00..0x09 in order, each 1 cycle after its re_i, empty=1 at the end.
- Overflow: with the FIFO full, hold we_i for 3 cycles, no reads -> ovf_cnt_o=3, level_o stays 10, the stored data is unchanged.
- Underflow and empty collision: with the FIFO empty, assert we_i=re_i=1 with data 0xA5 -> write accepted, udf_cnt_o=1, data_vld_o=0. Next cycle read -> data_o=0xA5.
- Full collision and wrap: with the FIFO full, assert we_i=re_i=1 for 25 cycles with an incrementing pattern -> level stays 10, ovf_cnt_o=0, and the read order matches the write order across pointer wrap (DEPTH=10 tests the non-power-of-two wrap).
- Clear and saturation: with CNT_WIDTH=2, cause 5 overflows -> ovf_cnt_o=3. Assert clr_stats_i while level=4 -> counters=0, max_level_o=4.
- Mid-operation reset: assert rst_i asynchronously with level=6 -> all outputs take their reset values immediately. After release, the first write and read return the new data.
